result_readout: RTL

- Downstream stage of the matrix-multiply datapath; owns the chip's result read port.
- Takes an external read request (read_n, r_addr) and fetches one 18-bit result word from the result SRAM.
- Returns the word over the 9-bit read_data pad bus in two consecutive cycles: low half, then high half.
- Sits between the result memory / ALU write side and the read_data / ry pads in top_top.

---
 rtl/readout_pkg.sv | 18 +
 rtl/result_readout.sv | 82 ++++++++
 2 files changed

// File: rtl/readout_pkg.sv
// Shared constants and state encoding for the result read port.
package readout_pkg;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned RES_DEPTH = 32;
    localparam int unsigned MEM_AW    = 5;
    localparam int unsigned DATA_W    = 18;
    localparam int unsigned HALF_W    = DATA_W / 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LO    = 3'd3,
        ST_HI    = 3'd4
    } state_t;

endpackage

// File: rtl/result_readout.sv
// Result read port: fetches one 18-bit result word and returns it as two 9-bit halves.
module result_readout
    import readout_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              read_n,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic              busy_in,
    output logic              ry,
    output logic [HALF_W-1:0] read_data,
    output logic              mem_cen_n,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state;
    state_t            state_d;
    logic              accept;
    logic              in_range;
    logic              oor;
    logic [DATA_W-1:0] word;

    assign in_range = (r_addr < ADDR_W'(RES_DEPTH));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, request acceptance and ready; ry is held low during reset
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        ry      = 1'b0;
        case (state)
            ST_IDLE: begin
                ry     = rst & ~busy_in;
                accept = ~read_n & ~busy_in;
                if (accept) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_LO;
            ST_LO:    state_d = ST_HI;
            ST_HI:    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // SRAM strobe, captured word and serialized half-word output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_cen_n <= 1'b1;
            mem_addr  <= '0;
            oor       <= 1'b0;
            word      <= '0;
            read_data <= '0;
        end else begin
            mem_cen_n <= 1'b1;
            if (accept) begin
                // Truncation is safe: out-of-range indices never enable the SRAM
                mem_addr  <= r_addr[MEM_AW-1:0];
                oor       <= ~in_range;
                mem_cen_n <= ~in_range;
            end
            if (state == ST_WAIT) begin
                word      <= oor ? '0 : mem_rdata;
                read_data <= oor ? '0 : mem_rdata[HALF_W-1:0];
            end
            if (state == ST_LO) begin
                read_data <= word[DATA_W-1:HALF_W];
            end
        end
    end

endmodule
